// File: rtl/clk_pwr_seq_if.sv
// Reprogram request channel between a PLL controller (master) and clk_pwr_seq (slave).
// Carries the valid/ready handshake plus the target PLL and its new divider pair.
interface clk_pwr_seq_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_pll_i;
  logic [3:0]  req_ref_div_i;
  logic [11:0] req_fb_div_i;

  modport master (
    output req_valid_i,
    output req_pll_i,
    output req_ref_div_i,
    output req_fb_div_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_pll_i,
    input  req_ref_div_i,
    input  req_fb_div_i,
    output req_ready_o
  );
endinterface

// File: rtl/clk_pwr_seq.sv
// Clock/reset power sequencer for clk_rst_gen: boots all domains, then serves PLL reprogram requests.
// Optional macro CLK_PWR_SEQ_LOCK_STATS_EN enables the lock_cycles_o wait-duration statistic.
module clk_pwr_seq #(
  parameter int unsigned GATE_CYCLES  = 4,
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter logic [3:0]  DEF_REF_DIV  = 4'd1,
  parameter logic [11:0] DEF_FB_DIV   = 12'd40
) (
  input  logic                clk_i,
  input  logic                srst_i,
  clk_pwr_seq_if.slave        req_if,
  input  logic [2:0]          pll_locked_i,
  output logic [11:0]         pll_ref_div_o,
  output logic [35:0]         pll_fb_div_o,
  output logic [4:0]          clk_en_o,
  output logic [4:0]          arst_no,
  output logic                done_o,
  output logic                err_o,
  output logic [15:0]         lock_cycles_o
);

  localparam logic [15:0] GATE_LAST = 16'(GATE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);
  localparam logic [15:0] STABLE_N  = 16'(LOCK_STABLE);
  localparam logic [15:0] TIMEOUT_N = 16'(LOCK_TIMEOUT);
  localparam logic [4:0]  DOM_ALL   = 5'h1F;

  typedef enum logic [2:0] {
    BOOT_LOCK,
    IDLE,
    GATE,
    PROGRAM,
    WAIT_LOCK,
    HOLD,
    ENABLE
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Domain bit order is {PL,SL,CL,P,E}; the shared CL domain follows both core PLLs.
  function automatic logic [4:0] dom_mask(input logic [1:0] pll);
    case (pll)
      2'd0:    return 5'b00101;
      2'd1:    return 5'b00110;
      2'd2:    return 5'b01000;
      default: return 5'b00000;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [4:0]  mask_q, mask_d;
  logic [1:0]  tgt_q, tgt_d;
  logic [3:0]  new_ref_q, new_ref_d;
  logic [11:0] new_fb_q, new_fb_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] stable_q, stable_d;
  logic [15:0] wait_q, wait_d;
  logic [4:0]  clk_en_q, clk_en_d;
  logic [4:0]  arst_n_q, arst_n_d;
  logic [11:0] ref_div_q, ref_div_d;
  logic [35:0] fb_div_q, fb_div_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [15:0] stable_inc;
  logic [15:0] wait_inc;
  logic [15:0] stable_nx;
  logic        tgt_locked;
  logic        lock_latch;

  assign stable_inc = sat_inc(stable_q);
  assign wait_inc   = sat_inc(wait_q);

  always_comb begin
    case (tgt_q)
      2'd0:    tgt_locked = pll_locked_i[0];
      2'd1:    tgt_locked = pll_locked_i[1];
      2'd2:    tgt_locked = pll_locked_i[2];
      default: tgt_locked = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    tgt_d      = tgt_q;
    new_ref_d  = new_ref_q;
    new_fb_d   = new_fb_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    wait_d     = wait_q;
    clk_en_d   = clk_en_q;
    arst_n_d   = arst_n_q;
    ref_div_d  = ref_div_q;
    fb_div_d   = fb_div_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    lock_latch = 1'b0;
    stable_nx  = 16'd0;

    case (state_q)
      BOOT_LOCK: begin
        mask_d    = DOM_ALL;
        stable_nx = (&pll_locked_i) ? stable_inc : 16'd0;
        stable_d  = stable_nx;
        wait_d    = wait_inc;
        if (stable_nx >= STABLE_N) begin
          state_d    = HOLD;
          cnt_d      = 16'd0;
          lock_latch = 1'b1;
        end else if (wait_inc >= TIMEOUT_N) begin
          err_d      = 1'b1;
          stable_d   = 16'd0;
          wait_d     = 16'd0;
          lock_latch = 1'b1;
        end
      end

      IDLE: begin
        if (req_if.req_valid_i && ready_q) begin
          if (req_if.req_pll_i == 2'd3) begin
            err_d = 1'b1;
          end else begin
            tgt_d     = req_if.req_pll_i;
            mask_d    = dom_mask(req_if.req_pll_i);
            new_ref_d = req_if.req_ref_div_i;
            new_fb_d  = req_if.req_fb_div_i;
            clk_en_d  = clk_en_q & ~dom_mask(req_if.req_pll_i);
            cnt_d     = 16'd0;
            state_d   = GATE;
          end
        end
      end

      GATE: begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == GATE_LAST) begin
          arst_n_d = arst_n_q & ~mask_q;
          state_d  = PROGRAM;
        end
      end

      PROGRAM: begin
        case (tgt_q)
          2'd0: begin ref_div_d[3:0]  = new_ref_q; fb_div_d[11:0]  = new_fb_q; end
          2'd1: begin ref_div_d[7:4]  = new_ref_q; fb_div_d[23:12] = new_fb_q; end
          2'd2: begin ref_div_d[11:8] = new_ref_q; fb_div_d[35:24] = new_fb_q; end
          default: ;
        endcase
        stable_d = 16'd0;
        wait_d   = 16'd0;
        state_d  = WAIT_LOCK;
      end

      WAIT_LOCK: begin
        // The PLL may report a stale lock right after reprogramming, so early samples are blanked.
        wait_d    = wait_inc;
        stable_nx = (wait_q < STABLE_N) ? 16'd0 : (tgt_locked ? stable_inc : 16'd0);
        stable_d  = stable_nx;
        if (stable_nx >= STABLE_N) begin
          state_d    = HOLD;
          cnt_d      = 16'd0;
          lock_latch = 1'b1;
        end else if (wait_inc >= TIMEOUT_N) begin
          err_d      = 1'b1;
          state_d    = IDLE;
          lock_latch = 1'b1;
        end
      end

      HOLD: begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == HOLD_LAST) begin
          arst_n_d = arst_n_q | mask_q;
          state_d  = ENABLE;
        end
      end

      ENABLE: begin
        clk_en_d = clk_en_q | mask_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = BOOT_LOCK;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= BOOT_LOCK;
      ready_q   <= 1'b0;
      cnt_q     <= 16'd0;
      stable_q  <= 16'd0;
      wait_q    <= 16'd0;
      clk_en_q  <= 5'd0;
      arst_n_q  <= 5'd0;
      ref_div_q <= {3{DEF_REF_DIV}};
      fb_div_q  <= {3{DEF_FB_DIV}};
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      wait_q    <= wait_d;
      clk_en_q  <= clk_en_d;
      arst_n_q  <= arst_n_d;
      ref_div_q <= ref_div_d;
      fb_div_q  <= fb_div_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Request capture registers are only consumed after a handshake, so they need no reset.
  always_ff @(posedge clk_i) begin
    mask_q    <= mask_d;
    tgt_q     <= tgt_d;
    new_ref_q <= new_ref_d;
    new_fb_q  <= new_fb_d;
  end

`ifdef CLK_PWR_SEQ_LOCK_STATS_EN
  logic [15:0] lock_cyc_q, lock_cyc_d;

  always_comb begin
    lock_cyc_d = lock_cyc_q;
    if (lock_latch) lock_cyc_d = wait_inc;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) lock_cyc_q <= 16'd0;
    else        lock_cyc_q <= lock_cyc_d;
  end

  assign lock_cycles_o = lock_cyc_q;
`else
  logic unused_lock_latch;
  assign unused_lock_latch = lock_latch;
  assign lock_cycles_o     = 16'd0;
`endif

  assign req_if.req_ready_o = ready_q;
  assign pll_ref_div_o      = ref_div_q;
  assign pll_fb_div_o       = fb_div_q;
  assign clk_en_o           = clk_en_q;
  assign arst_no            = arst_n_q;
  assign done_o             = done_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_clk_pwr_seq.sv
// Directed-sequence bench for clk_pwr_seq with randomized lock waveforms and divider values.
// Expected outputs come from a timeline model built from the sequencing rules.
module tb_clk_pwr_seq;
  localparam int GATE_CYCLES  = 4;
  localparam int RST_HOLD     = 16;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        srst;
  logic [2:0]  locked;
  logic [11:0] ref_div;
  logic [35:0] fb_div;
  logic [4:0]  clk_en;
  logic [4:0]  arst_n;
  logic        done;
  logic        err;
  logic [15:0] lock_cycles;

  clk_pwr_seq_if req_if();

  clk_pwr_seq dut (
    .clk_i         (clk),
    .srst_i        (srst),
    .req_if        (req_if.slave),
    .pll_locked_i  (locked),
    .pll_ref_div_o (ref_div),
    .pll_fb_div_o  (fb_div),
    .clk_en_o      (clk_en),
    .arst_no       (arst_n),
    .done_o        (done),
    .err_o         (err),
    .lock_cycles_o (lock_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [4:0]  m_en;
  logic [4:0]  m_rst;
  logic [11:0] m_ref;
  logic [35:0] m_fb;
  logic [15:0] m_lc;
  bit          lk_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_en  = 5'd0;
    m_rst = 5'd0;
    m_ref = {3{4'd1}};
    m_fb  = {3{12'd40}};
    m_lc  = 16'd0;
  endtask

  function automatic logic [4:0] dmask(input int pll);
    case (pll)
      0:       return 5'b00101;
      1:       return 5'b00110;
      2:       return 5'b01000;
      default: return 5'b00000;
    endcase
  endfunction

  // Cycle (1-based) at which LOCK_STABLE consecutive counted lock samples are seen, -1 on timeout.
  function automatic int lock_wait(input int blank);
    int st;
    bit v;
    st = 0;
    for (int k = 1; k <= LOCK_TIMEOUT; k++) begin
      v = (k - 1 < lk_q.size()) ? lk_q[k-1] : 1'b0;
      if (k > blank) st = v ? st + 1 : 0;
      if (st == LOCK_STABLE) return k;
    end
    return -1;
  endfunction

  task automatic check_all(input string tag, input bit rdy, input bit dn, input bit er);
    chk({tag, ".clk_en"}, clk_en, m_en);
    chk({tag, ".arst_n"}, arst_n, m_rst);
    chk({tag, ".ref_div"}, ref_div, m_ref);
    chk({tag, ".fb_div"}, fb_div, m_fb);
    chk({tag, ".ready"}, req_if.req_ready_o, rdy);
    chk({tag, ".done"}, done, dn);
    chk({tag, ".err"}, err, er);
`ifdef CLK_PWR_SEQ_LOCK_STATS_EN
    chk({tag, ".lock_cycles"}, lock_cycles, m_lc);
`else
    chk({tag, ".lock_cycles"}, lock_cycles, 16'd0);
`endif
  endtask

  task automatic finish_seq(input string tag, input logic [4:0] mask);
    for (int h = 1; h <= RST_HOLD; h++) begin
      step();
      if (h == RST_HOLD) m_rst = m_rst | mask;
      check_all({tag, ".hold"}, 1'b0, 1'b0, 1'b0);
    end
    step();
    m_en = m_en | mask;
    check_all({tag, ".enable"}, 1'b1, 1'b1, 1'b0);
    step();
    check_all({tag, ".idle"}, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic boot(input int pre_low, input int rnd_len);
    int w;
    lk_q.delete();
    repeat (pre_low) lk_q.push_back(1'b0);
    repeat (rnd_len) lk_q.push_back(1'($urandom_range(0, 1)));
    repeat (2 * LOCK_STABLE) lk_q.push_back(1'b1);
    w = lock_wait(0);
    srst = 1'b0;
    for (int k = 1; k <= w; k++) begin
      locked = lk_q[k-1] ? 3'b111 : 3'($urandom_range(0, 6));
      step();
      if (k == w) m_lc = 16'(w);
      check_all("boot.wait", 1'b0, 1'b0, 1'b0);
    end
    locked = 3'b111;
    finish_seq("boot", 5'h1F);
  endtask

  // kind: 0 random lock waveform, 1 single-cycle glitch after 6 stable, 2 lock never arrives.
  task automatic request(input int pll, input logic [3:0] rd, input logic [11:0] fd,
                         input int kind, input int abort_at);
    logic [4:0] mask;
    logic [2:0] l;
    int w, last;
    mask = dmask(pll);
    lk_q.delete();
    case (kind)
      0: begin
        repeat ($urandom_range(0, 12)) lk_q.push_back(1'b0);
        repeat ($urandom_range(0, 10)) lk_q.push_back(1'($urandom_range(0, 1)));
        repeat (2 * LOCK_STABLE + 2) lk_q.push_back(1'b1);
      end
      1: begin
        repeat (LOCK_STABLE + 6) lk_q.push_back(1'b1);
        lk_q.push_back(1'b0);
        repeat (LOCK_STABLE + 2) lk_q.push_back(1'b1);
      end
      default: repeat (LOCK_TIMEOUT) lk_q.push_back(1'b0);
    endcase
    w    = lock_wait(LOCK_STABLE);
    last = (w < 0) ? LOCK_TIMEOUT : w;

    chk("req.ready_before", req_if.req_ready_o, 1'b1);
    req_if.req_valid_i   = 1'b1;
    req_if.req_pll_i     = 2'(pll);
    req_if.req_ref_div_i = rd;
    req_if.req_fb_div_i  = fd;
    step();
    req_if.req_valid_i = 1'b0;
    m_en = m_en & ~mask;
    check_all("req.gate_entry", 1'b0, 1'b0, 1'b0);

    for (int g = 1; g <= GATE_CYCLES; g++) begin
      step();
      if (g == GATE_CYCLES) m_rst = m_rst & ~mask;
      check_all("req.gate", 1'b0, 1'b0, 1'b0);
    end

    step();
    case (pll)
      0: begin m_ref[3:0]  = rd; m_fb[11:0]  = fd; end
      1: begin m_ref[7:4]  = rd; m_fb[23:12] = fd; end
      default: begin m_ref[11:8] = rd; m_fb[35:24] = fd; end
    endcase
    check_all("req.program", 1'b0, 1'b0, 1'b0);

    for (int k = 1; k <= last; k++) begin
      l = 3'($urandom);
      l[pll] = (k - 1 < lk_q.size()) ? lk_q[k-1] : 1'b0;
      locked = l;
      if (k == abort_at) srst = 1'b1;
      step();
      if (k == abort_at) begin
        reset_model();
        check_all("req.abort_reset", 1'b0, 1'b0, 1'b0);
        return;
      end
      if (k == last) m_lc = 16'(last);
      if (w < 0 && k == last) begin
        check_all("req.timeout", 1'b1, 1'b0, 1'b1);
        step();
        check_all("req.after_timeout", 1'b1, 1'b0, 1'b0);
      end else begin
        check_all("req.wait_lock", 1'b0, 1'b0, 1'b0);
      end
    end
    locked = 3'b111;
    if (w >= 0) finish_seq("req", mask);
  endtask

  task automatic reserved_req();
    chk("rsv.ready_before", req_if.req_ready_o, 1'b1);
    req_if.req_valid_i   = 1'b1;
    req_if.req_pll_i     = 2'd3;
    req_if.req_ref_div_i = 4'($urandom);
    req_if.req_fb_div_i  = 12'($urandom);
    step();
    req_if.req_valid_i = 1'b0;
    check_all("rsv.err", 1'b1, 1'b0, 1'b1);
    step();
    check_all("rsv.after", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    srst                 = 1'b1;
    locked               = 3'b000;
    req_if.req_valid_i   = 1'b0;
    req_if.req_pll_i     = 2'd0;
    req_if.req_ref_div_i = 4'd0;
    req_if.req_fb_div_i  = 12'd0;
    reset_model();
    repeat (3) step();
    check_all("reset", 1'b0, 1'b0, 1'b0);

    boot(4, 0);
    request(0, 4'd2, 12'd80, 0, 0);
    request(1, 4'($urandom), 12'($urandom), 0, 0);
    request(2, 4'($urandom), 12'($urandom), 1, 0);
    reserved_req();
    repeat (3) request($urandom_range(0, 2), 4'($urandom), 12'($urandom), 0, 0);
    request(2, 4'($urandom), 12'($urandom), 2, 0);
    request(2, 4'($urandom), 12'($urandom), 0, 0);
    request(0, 4'($urandom), 12'($urandom), 0, 5);
    boot($urandom_range(0, 6), $urandom_range(0, 12));
    request(1, 4'($urandom), 12'($urandom), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
